// File: rtl/cla_seq_adder_pkg.sv
// Shared types and constants for the sequential carry look-ahead adder.
// State encodings, the nibble width and the step-count helper live here.
package cla_seq_adder_pkg;

   localparam int NIB = 4;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_e;

   function automatic int nib_steps(input int width);
      return width / NIB;
   endfunction

endpackage

// File: rtl/cla_seq_adder_cla4.sv
// Purely combinational 4-bit carry look-ahead adder, shared by the sequencer.
module cla4
   import cla_seq_adder_pkg::*;
(
   input  logic [NIB-1:0] a,
   input  logic [NIB-1:0] b,
   input  logic           ci,
   output logic [NIB-1:0] s,
   output logic           co
);

   logic [NIB-1:0] g_s;
   logic [NIB-1:0] p_s;
   logic [NIB:0]   c_s;

   assign g_s = a & b;
   assign p_s = a ^ b;

   // Every carry is flattened from generate/propagate terms; no ripple path.
   assign c_s[0] = ci;
   assign c_s[1] = g_s[0] | (p_s[0] & ci);
   assign c_s[2] = g_s[1] | (p_s[1] & g_s[0]) | (p_s[1] & p_s[0] & ci);
   assign c_s[3] = g_s[2] | (p_s[2] & g_s[1]) | (p_s[2] & p_s[1] & g_s[0])
                 | (p_s[2] & p_s[1] & p_s[0] & ci);
   assign c_s[4] = g_s[3] | (p_s[3] & g_s[2]) | (p_s[3] & p_s[2] & g_s[1])
                 | (p_s[3] & p_s[2] & p_s[1] & g_s[0])
                 | (p_s[3] & p_s[2] & p_s[1] & p_s[0] & ci);

   assign s  = p_s ^ c_s[NIB-1:0];
   assign co = c_s[NIB];

endmodule

// File: rtl/cla_seq_adder.sv
// WIDTH-bit adder that runs one nibble per clock through a single cla4.
// Optional subtraction (op/ovf ports) is enabled by defining SUBTRACT_EN.
module cla_seq_adder
   import cla_seq_adder_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             ci,
`ifdef SUBTRACT_EN
   input  logic             op,
   output logic             ovf,
`endif
   output logic [WIDTH-1:0] sum,
   output logic             co,
   output logic             busy,
   output logic             done
);

   localparam int              N        = nib_steps(WIDTH);
   localparam int              IDXW     = $clog2(N);
   localparam logic [IDXW-1:0] IDX_LAST = IDXW'(N - 1);

   state_e           state_q;
   logic [IDXW-1:0]  idx_q;
   logic             carry_q;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic [WIDTH-1:0] sum_q;
   logic             co_q;
   logic             busy_q;
   logic             done_q;
`ifdef SUBTRACT_EN
   logic             ovf_q;
`endif

   logic [NIB-1:0]   a_nib_s;
   logic [NIB-1:0]   b_nib_s;
   logic [NIB-1:0]   s_nib_s;
   logic             co_nib_s;
   logic [WIDTH-1:0] sum_d;
   logic             last_s;

   // Slice the current nibble out of the captured operands and merge the result back.
   always_comb begin
      a_nib_s = a_q[NIB*int'(idx_q) +: NIB];
      b_nib_s = b_q[NIB*int'(idx_q) +: NIB];
      sum_d   = sum_q;
      sum_d[NIB*int'(idx_q) +: NIB] = s_nib_s;
      last_s  = (idx_q == IDX_LAST);
   end

   cla4 u_cla4 (
      .a  (a_nib_s),
      .b  (b_nib_s),
      .ci (carry_q),
      .s  (s_nib_s),
      .co (co_nib_s)
   );

   // Control FSM, nibble counter and all result registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         idx_q   <= '0;
         carry_q <= 1'b0;
         a_q     <= '0;
         b_q     <= '0;
         sum_q   <= '0;
         co_q    <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
`ifdef SUBTRACT_EN
         ovf_q   <= 1'b0;
`endif
      end else begin
         case (state_q)
            S_IDLE, S_DONE: begin
               done_q <= 1'b0;
               if (start) begin
                  state_q <= S_RUN;
                  busy_q  <= 1'b1;
                  idx_q   <= '0;
                  a_q     <= a;
                  sum_q   <= '0;
                  co_q    <= 1'b0;
`ifdef SUBTRACT_EN
                  // Subtraction is a + ~b + 1; the caller's ci is deliberately ignored.
                  b_q     <= op ? ~b : b;
                  carry_q <= op ? 1'b1 : ci;
                  ovf_q   <= 1'b0;
`else
                  b_q     <= b;
                  carry_q <= ci;
`endif
               end else begin
                  state_q <= S_IDLE;
                  busy_q  <= 1'b0;
               end
            end
            S_RUN: begin
               sum_q   <= sum_d;
               carry_q <= co_nib_s;
               if (last_s) begin
                  state_q <= S_DONE;
                  idx_q   <= '0;
                  co_q    <= co_nib_s;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
`ifdef SUBTRACT_EN
                  ovf_q   <= (a_q[WIDTH-1] == b_q[WIDTH-1]) &&
                             (s_nib_s[NIB-1] != a_q[WIDTH-1]);
`endif
               end else begin
                  state_q <= S_RUN;
                  idx_q   <= idx_q + IDXW'(1);
                  busy_q  <= 1'b1;
                  done_q  <= 1'b0;
               end
            end
            default: begin
               state_q <= S_IDLE;
               idx_q   <= '0;
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
            end
         endcase
      end
   end

   assign sum  = sum_q;
   assign co   = co_q;
   assign busy = busy_q;
   assign done = done_q;
`ifdef SUBTRACT_EN
   assign ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_cla_seq_adder.sv
// Self-checking bench for cla_seq_adder (WIDTH=16) against a plain-arithmetic model.
// Subtraction checks are compiled in only when SUBTRACT_EN is defined.
module tb_cla_seq_adder;

   localparam int W = 16;
   localparam int N = W / 4;

   logic         clk = 1'b0;
   logic         rst;
   logic         start;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         ci;
   logic [W-1:0] sum;
   logic         co;
   logic         busy;
   logic         done;
`ifdef SUBTRACT_EN
   logic         op;
   logic         ovf;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   cla_seq_adder #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .a     (a),
      .b     (b),
      .ci    (ci),
`ifdef SUBTRACT_EN
      .op    (op),
      .ovf   (ovf),
`endif
      .sum   (sum),
      .co    (co),
      .busy  (busy),
      .done  (done)
   );

   always #5 clk = ~clk;

   function automatic logic [W:0] ref_add(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
      return {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
   endfunction

   // Launch an operation: start is high for the cycle following this call (cycle 0).
   task automatic start_op(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tci);
      @(posedge clk);
      #1;
      a = ta; b = tb; ci = tci; start = 1'b1;
   endtask

   // From cycle 0, step cycles until done; reports done cycle and busy-pattern errors.
   task automatic wait_done(input bit hold, input logic [W-1:0] na, input logic [W-1:0] nb,
                            output int dcyc, output int busy_err);
      dcyc = -1;
      busy_err = 0;
      for (int k = 1; k <= 3 * N; k++) begin
         @(posedge clk);
         #1;
         if (k == 1) begin
            if (hold) begin
               a = na; b = nb;
            end else begin
               start = 1'b0;
               a = W'($urandom); b = W'($urandom);
            end
         end
         @(negedge clk);
         if (done === 1'b1) begin
            dcyc = k;
            if (busy !== 1'b0) busy_err++;
            break;
         end else if (busy !== 1'b1) begin
            busy_err++;
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 1'b1; a = 16'hABCD; b = 16'h1234; ci = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      n_checks++; if (sum !== 16'h0000) begin n_fail++; $display("FAIL reset_sum: got %h want %h", sum, 16'h0000); end
      n_checks++; if (co !== 1'b0) begin n_fail++; $display("FAIL reset_co: got %b want 0", co); end
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
      n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", done); end
      @(posedge clk);
      #1;
      rst = 1'b0; start = 1'b0;
   endtask

   task automatic test_carry_wrap();
      int dcyc, berr;
      start_op(16'hFFFF, 16'h0001, 1'b0);
      wait_done(1'b0, '0, '0, dcyc, berr);
      n_checks++; if (dcyc !== 5) begin n_fail++; $display("FAIL wrap_done_cycle: got %0d want 5", dcyc); end
      n_checks++; if (berr !== 0) begin n_fail++; $display("FAIL wrap_busy: %0d bad busy cycles want 0", berr); end
      n_checks++; if (sum !== 16'h0000) begin n_fail++; $display("FAIL wrap_sum: got %h want 0000", sum); end
      n_checks++; if (co !== 1'b1) begin n_fail++; $display("FAIL wrap_co: got %b want 1", co); end
   endtask

   task automatic test_pulse();
      int dcyc, berr;
      start_op(16'h1234, 16'h4321, 1'b1);
      wait_done(1'b0, '0, '0, dcyc, berr);
      n_checks++; if (sum !== 16'h5556) begin n_fail++; $display("FAIL pulse_sum: got %h want 5556", sum); end
      n_checks++; if (co !== 1'b0) begin n_fail++; $display("FAIL pulse_co: got %b want 0", co); end
      @(negedge clk);
      n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL pulse_width: done %b one cycle later want 0", done); end
      n_checks++; if (sum !== 16'h5556) begin n_fail++; $display("FAIL pulse_hold: got %h want 5556", sum); end
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL pulse_idle_busy: got %b want 0", busy); end
   endtask

   task automatic test_start_held();
      int d1, d2, berr;
      logic [W-1:0] na, nb;
      logic [W:0]   exp2;
      na = W'($urandom); nb = W'($urandom);
      exp2 = ref_add(na, nb, 1'b1);
      start_op(16'h1234, 16'h4321, 1'b1);
      wait_done(1'b1, na, nb, d1, berr);
      n_checks++; if (d1 !== 5) begin n_fail++; $display("FAIL held_done1: got cycle %0d want 5", d1); end
      n_checks++; if (sum !== 16'h5556) begin n_fail++; $display("FAIL held_sum1: got %h want 5556", sum); end
      wait_done(1'b0, '0, '0, d2, berr);
      n_checks++; if (d1 + d2 !== 10) begin n_fail++; $display("FAIL held_done2: got cycle %0d want 10", d1 + d2); end
      n_checks++; if ({co, sum} !== exp2) begin n_fail++; $display("FAIL held_sum2: got %h want %h", {co, sum}, exp2); end
   endtask

   task automatic test_abort();
      int ndone;
      start_op(16'h1111, 16'h2222, 1'b0);
      @(posedge clk); #1; start = 1'b0;
      @(posedge clk); #1; rst = 1'b1;
      @(posedge clk); #1; rst = 1'b0;
      @(negedge clk);
      n_checks++; if (sum !== 16'h0000) begin n_fail++; $display("FAIL abort_sum: got %h want 0000", sum); end
      n_checks++; if (co !== 1'b0) begin n_fail++; $display("FAIL abort_co: got %b want 0", co); end
      n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL abort_done: got %b want 0", done); end
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy: got %b want 0", busy); end
      ndone = 0;
      for (int k = 0; k < 3 * N; k++) begin
         @(negedge clk);
         if (done === 1'b1) ndone++;
      end
      n_checks++; if (ndone !== 0) begin n_fail++; $display("FAIL abort_no_done: got %0d done pulses want 0", ndone); end
   endtask

   task automatic test_back_to_back();
      int d1, d2, berr;
      logic [W-1:0] ra, rb;
      logic         rc;
      logic [W:0]   exp1;
      ra = W'($urandom); rb = W'($urandom); rc = 1'($urandom);
      exp1 = ref_add(ra, rb, rc);
      start_op(ra, rb, rc);
      wait_done(1'b0, '0, '0, d1, berr);
      n_checks++; if ({co, sum} !== exp1) begin n_fail++; $display("FAIL b2b_first: got %h want %h", {co, sum}, exp1); end
      a = 16'h00FF; b = 16'h0001; ci = 1'b0; start = 1'b1;
      wait_done(1'b0, '0, '0, d2, berr);
      n_checks++; if (d2 !== 5) begin n_fail++; $display("FAIL b2b_latency: got %0d want 5", d2); end
      n_checks++; if (berr !== 0) begin n_fail++; $display("FAIL b2b_busy: %0d bad busy cycles want 0", berr); end
      n_checks++; if (sum !== 16'h0100) begin n_fail++; $display("FAIL b2b_sum: got %h want 0100", sum); end
      n_checks++; if (co !== 1'b0) begin n_fail++; $display("FAIL b2b_co: got %b want 0", co); end
   endtask

   task automatic test_random();
      int dcyc, berr;
      logic [W-1:0] ra, rb;
      logic         rc;
      logic [W:0]   exp;
      for (int i = 0; i < 16; i++) begin
         ra = W'($urandom); rb = W'($urandom); rc = 1'($urandom);
         if (i == 0) begin ra = 16'hFFFF; rb = 16'hFFFF; rc = 1'b1; end
         exp = ref_add(ra, rb, rc);
         start_op(ra, rb, rc);
         wait_done(1'b0, '0, '0, dcyc, berr);
         n_checks++; if (dcyc !== N + 1) begin n_fail++; $display("FAIL rand_latency[%0d]: got %0d want %0d", i, dcyc, N + 1); end
         n_checks++; if ({co, sum} !== exp) begin n_fail++; $display("FAIL rand_result[%0d]: %h+%h+%b got %h want %h", i, ra, rb, rc, {co, sum}, exp); end
         n_checks++; if (berr !== 0) begin n_fail++; $display("FAIL rand_busy[%0d]: %0d bad busy cycles want 0", i, berr); end
      end
   endtask

`ifdef SUBTRACT_EN
   task automatic test_subtract();
      int dcyc, berr, full;
      logic [W-1:0] ra, rb, exp_s;
      logic         exp_c, exp_v;
      op = 1'b1;
      start_op(16'h8000, 16'h0001, 1'b0);
      wait_done(1'b0, '0, '0, dcyc, berr);
      n_checks++; if (sum !== 16'h7FFF) begin n_fail++; $display("FAIL sub1_sum: got %h want 7fff", sum); end
      n_checks++; if (co !== 1'b1) begin n_fail++; $display("FAIL sub1_co: got %b want 1", co); end
      n_checks++; if (ovf !== 1'b1) begin n_fail++; $display("FAIL sub1_ovf: got %b want 1", ovf); end
      start_op(16'h0003, 16'h0005, 1'b1);
      wait_done(1'b0, '0, '0, dcyc, berr);
      n_checks++; if (sum !== 16'hFFFE) begin n_fail++; $display("FAIL sub2_sum: got %h want fffe", sum); end
      n_checks++; if (co !== 1'b0) begin n_fail++; $display("FAIL sub2_co: got %b want 0", co); end
      n_checks++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL sub2_ovf: got %b want 0", ovf); end
      for (int i = 0; i < 8; i++) begin
         ra = W'($urandom); rb = W'($urandom);
         exp_s = ra - rb;
         exp_c = (ra >= rb);
         full  = int'($signed(ra)) - int'($signed(rb));
         exp_v = (full > 32767) || (full < -32768);
         start_op(ra, rb, 1'($urandom));
         wait_done(1'b0, '0, '0, dcyc, berr);
         n_checks++; if ({co, ovf, sum} !== {exp_c, exp_v, exp_s}) begin
            n_fail++; $display("FAIL sub_rand[%0d]: %h-%h got co=%b ovf=%b %h want co=%b ovf=%b %h", i, ra, rb, co, ovf, sum, exp_c, exp_v, exp_s);
         end
      end
      op = 1'b0;
   endtask
`endif

   initial begin
      rst = 1'b1; start = 1'b0; a = '0; b = '0; ci = 1'b0;
`ifdef SUBTRACT_EN
      op = 1'b0;
`endif
      test_reset();
      test_carry_wrap();
      test_pulse();
      test_start_held();
      test_abort();
      test_back_to_back();
      test_random();
`ifdef SUBTRACT_EN
      test_subtract();
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog expired");
   end

endmodule
